// File: rtl/fft_pkg.sv
// Shared helpers and FSM encoding for the iterative radix-2 FFT engine.
// Elaboration-time only: no latency and no flow control of its own.
// Provides clog2, bit reversal and rounded Q(FRAC_W) twiddle constants.
package fft_pkg;

    typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_UNLOAD} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Round half away from zero so cos(pi/4) in Q16 lands on 46341.
    function automatic int tw_q(input int idx, input int n, input int frac, input bit sel_sin);
        real ang, v;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(n);
        v   = (sel_sin ? $sin(ang) : $cos(ang)) * real'(1 << frac);
        return (v < 0.0) ? $rtoi(v - 0.5) : $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Complex radix-2 DIT butterfly: y0 = a + W*b, y1 = a - W*b, optional >>>1.
// Purely combinational, zero latency.
// No flow control; the caller decides when results are committed.
module fft_bfly #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic              inv,
    input  logic              scale,
    output logic [DATA_W-1:0] y0_re,
    output logic [DATA_W-1:0] y0_im,
    output logic [DATA_W-1:0] y1_re,
    output logic [DATA_W-1:0] y1_im
);
    localparam int PW = 2 * DATA_W + 1;

    logic [DATA_W-1:0]    w_im_c, t_re, t_im, s0_re, s0_im, s1_re, s1_im;
    logic signed [PW-1:0] br, bi, wr, wi, pr, pi;

    assign w_im_c = inv ? -w_im : w_im;

    assign br = {{(DATA_W + 1){b_re[DATA_W-1]}}, b_re};
    assign bi = {{(DATA_W + 1){b_im[DATA_W-1]}}, b_im};
    assign wr = {{(DATA_W + 1){w_re[DATA_W-1]}}, w_re};
    assign wi = {{(DATA_W + 1){w_im_c[DATA_W-1]}}, w_im_c};

    // Products summed at full width, then truncated back to DATA_W after the shift.
    assign pr   = br * wr - bi * wi;
    assign pi   = br * wi + bi * wr;
    assign t_re = DATA_W'(pr >>> FRAC_W);
    assign t_im = DATA_W'(pi >>> FRAC_W);

    assign s0_re = a_re + t_re;
    assign s0_im = a_im + t_im;
    assign s1_re = a_re - t_re;
    assign s1_im = a_im - t_im;

    assign y0_re = scale ? {s0_re[DATA_W-1], s0_re[DATA_W-1:1]} : s0_re;
    assign y0_im = scale ? {s0_im[DATA_W-1], s0_im[DATA_W-1:1]} : s0_im;
    assign y1_re = scale ? {s1_re[DATA_W-1], s1_re[DATA_W-1:1]} : s1_re;
    assign y1_im = scale ? {s1_im[DATA_W-1], s1_im[DATA_W-1:1]} : s1_im;

endmodule

// File: rtl/fft_iter_core.sv
// In-place iterative radix-2 DIT FFT: bit-reversed load, one butterfly/cycle, natural-order unload.
// Latency: first output valid L*N/2+1 cycles after the last input handshake.
// s_ready only in LOAD; output held stable while m_ready is low.
module fft_iter_core
    import fft_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_re,
    input  logic [DATA_W-1:0] s_im,
    input  logic              mode_inv,
    input  logic              mode_scale,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_re,
    output logic [DATA_W-1:0] m_im,
    output logic              m_last,
    output logic              busy
);
    localparam int L  = clog2(N);
    localparam int SW = clog2(L);
    localparam int BW = L - 1;
    localparam logic [L-1:0]  K_LAST = L'(N - 1);
    localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(L - 1);

    state_t            st, st_nxt;
    logic [L-1:0]      k, j, top, bot;
    logic [BW-1:0]     b, tw;
    logic [SW-1:0]     stg;
    logic              inv_q, scale_q, out_vld, s_fire, m_fire;
    logic [DATA_W-1:0] mem_re [N];
    logic [DATA_W-1:0] mem_im [N];
    logic [DATA_W-1:0] rom_re [N/2];
    logic [DATA_W-1:0] rom_im [N/2];
    logic [DATA_W-1:0] y0_re, y0_im, y1_re, y1_im;
    int unsigned       half_i, b_i, stg_i, top_i;

    for (genvar g = 0; g < N / 2; g++) begin : g_rom
        assign rom_re[g] = DATA_W'(tw_q(g, N, FRAC_W, 1'b0));
        assign rom_im[g] = DATA_W'(-tw_q(g, N, FRAC_W, 1'b1));
    end

    assign s_fire = s_valid & s_ready;
    assign m_fire = out_vld & m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_LOAD;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        s_ready = 1'b0;
        busy    = 1'b1;
        case (st)
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid && k == K_LAST) st_nxt = ST_CALC;
            end
            ST_CALC:   if (stg == S_LAST && b == B_LAST) st_nxt = ST_UNLOAD;
            ST_UNLOAD: if (m_fire && j == K_LAST) st_nxt = ST_LOAD;
            default:   st_nxt = ST_LOAD;
        endcase
    end

    // out_vld lags UNLOAD entry by one cycle, giving the +1 in the output latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            b       <= '0;
            stg     <= '0;
            j       <= '0;
            inv_q   <= 1'b0;
            scale_q <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            if (s_fire) begin
                k <= k + 1'b1;
                if (k == '0) begin
                    inv_q   <= mode_inv;
                    scale_q <= mode_scale;
                end
            end
            if (st == ST_CALC) begin
                b <= b + 1'b1;
                if (b == B_LAST) stg <= (stg == S_LAST) ? '0 : stg + 1'b1;
            end
            if (m_fire) j <= j + 1'b1;
            out_vld <= (st == ST_UNLOAD) && !(m_fire && j == K_LAST);
        end
    end

    always_comb begin
        stg_i  = 32'(stg);
        b_i    = 32'(b);
        half_i = 32'd1 << stg_i;
        top_i  = ((b_i >> stg_i) << (stg_i + 1)) | (b_i & (half_i - 1));
        top    = L'(top_i);
        bot    = L'(top_i + half_i);
        tw     = BW'((b_i & (half_i - 1)) << (32'(BW) - stg_i));
    end

    fft_bfly #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_bfly (
        .a_re  (mem_re[top]),
        .a_im  (mem_im[top]),
        .b_re  (mem_re[bot]),
        .b_im  (mem_im[bot]),
        .w_re  (rom_re[tw]),
        .w_im  (rom_im[tw]),
        .inv   (inv_q),
        .scale (scale_q),
        .y0_re (y0_re),
        .y0_im (y0_im),
        .y1_re (y1_re),
        .y1_im (y1_im)
    );

    always_ff @(posedge clk) begin
        if (s_fire) begin
            mem_re[L'(bitrev(32'(k), L))] <= s_re;
            mem_im[L'(bitrev(32'(k), L))] <= s_im;
        end else if (st == ST_CALC) begin
            mem_re[top] <= y0_re;
            mem_im[top] <= y0_im;
            mem_re[bot] <= y1_re;
            mem_im[bot] <= y1_im;
        end
    end

    assign m_valid = out_vld;
    assign m_last  = out_vld && (j == K_LAST);
    assign m_re    = mem_re[j];
    assign m_im    = mem_im[j];

endmodule

// File: tb/tb_fft_iter_core.sv
// Scoreboard bench for fft_iter_core at N=8, Q16.16.
// Expected bins are queued at stimulus time and popped on each output handshake.
module tb_fft_iter_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_re = '0;
    logic [31:0] s_im = '0;
    logic        mode_inv = 1'b0;
    logic        mode_scale = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_re, m_im;
    logic        m_last;
    logic        busy;

    always #5 clk = ~clk;

    fft_iter_core #(.N(8), .DATA_W(32), .FRAC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .mode_inv   (mode_inv),
        .mode_scale (mode_scale),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_last     (m_last),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fr_re [8];
    logic [31:0] fr_im [8];
    logic [31:0] ex_re [8];
    logic [31:0] ex_im [8];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic clr();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
            ex_re[i] = '0;
            ex_im[i] = '0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.re   = ex_re[i];
            e.im   = ex_im[i];
            e.last = (i == 7);
            sb.push_back(e);
        end
    endtask

    // Modes are driven inverted on samples 1..7; only sample 0 may latch them.
    task automatic send(input bit inv, input bit scale, input bit gaps);
        int  k;
        int  cyc;
        bit  hs;
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 500) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid    = 1'b1;
                s_re       = fr_re[k];
                s_im       = fr_im[k];
                mode_inv   = (k == 0) ? inv : ~inv;
                mode_scale = (k == 0) ? scale : ~scale;
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            cyc++;
        end
        s_valid = 1'b0;
        if (k < 8) chk("load_timeout", 96'(k), 96'd8);
    endtask

    // Garbage is offered while busy; none of it may be accepted.
    task automatic wait_out();
        int cyc;
        cyc = 0;
        chk("busy_calc", {s_ready, busy, m_valid}, 3'b010);
        s_valid = 1'b1;
        s_re    = 32'hDEAD_BEEF;
        s_im    = 32'h1234_5678;
        while (!m_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        chk("latency", 96'(cyc), 96'd13);
    endtask

    task automatic recv(input bit toggle);
        int          got;
        int          cyc;
        bit          ph;
        bit          held;
        logic [31:0] hr, hi;
        logic        hl;
        exp_t        e;
        got  = 0;
        cyc  = 0;
        ph   = 1'b1;
        held = 1'b0;
        while (got < 8 && cyc < 200) begin
            m_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            @(negedge clk);
            if (held) begin
                chk($sformatf("stall_bin%0d", got), {m_re, m_im, m_last}, {hr, hi, hl});
                held = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 96'(sb.size()), 96'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("bin%0d_re", got), 96'(m_re), 96'(e.re));
                    chk($sformatf("bin%0d_im", got), 96'(m_im), 96'(e.im));
                    chk($sformatf("bin%0d_last", got), 96'(m_last), 96'(e.last));
                end
                got++;
            end else if (m_valid) begin
                hr   = m_re;
                hi   = m_im;
                hl   = m_last;
                held = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        m_ready = 1'b0;
        if (got < 8) chk("unload_timeout", 96'(got), 96'd8);
        chk("ready_after_unload", {s_ready, m_valid, busy}, 3'b100);
    endtask

    task automatic run(input bit inv, input bit scale, input bit gaps, input bit toggle);
        push_exp();
        send(inv, scale, gaps);
        wait_out();
        recv(toggle);
    endtask

    initial begin
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_s_ready", 96'(s_ready), 96'd1);
        chk("rst_m_valid", 96'(m_valid), 96'd0);
        chk("rst_m_last", 96'(m_last), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);

        // Impulse: flat spectrum
        clr();
        fr_re[0] = 32'h0001_0000;
        for (int i = 0; i < 8; i++) ex_re[i] = 32'h0001_0000;
        run(1'b0, 1'b0, 1'b0, 1'b0);

        // DC, unscaled and scaled
        clr();
        for (int i = 0; i < 8; i++) fr_re[i] = 32'h0001_0000;
        ex_re[0] = 32'h0008_0000;
        run(1'b0, 1'b0, 1'b0, 1'b0);
        ex_re[0] = 32'h0001_0000;
        run(1'b0, 1'b1, 1'b0, 1'b0);

        // Two-point: 17 + 4096*W^k, with W1 = 46341*(1 - j) in Q16
        clr();
        fr_re[0] = 32'h0011_0000;
        fr_re[1] = 32'h1000_0000;
        ex_re = '{32'h1011_0000, 32'h0B61_5000, 32'h0011_0000, 32'hF4C0_B000,
                  32'hF011_0000, 32'hF4C0_B000, 32'h0011_0000, 32'h0B61_5000};
        ex_im = '{32'h0000_0000, 32'hF4AF_B000, 32'hF000_0000, 32'hF4AF_B000,
                  32'h0000_0000, 32'h0B50_5000, 32'h1000_0000, 32'h0B50_5000};
        run(1'b0, 1'b0, 1'b0, 1'b0);

        // Scaled inverse of an 8x DC bin
        clr();
        fr_re[0] = 32'h0008_0000;
        for (int i = 0; i < 8; i++) ex_re[i] = 32'h0001_0000;
        run(1'b1, 1'b1, 1'b0, 1'b0);

        // Backpressure on DC
        clr();
        for (int i = 0; i < 8; i++) fr_re[i] = 32'h0001_0000;
        ex_re[0] = 32'h0008_0000;
        run(1'b0, 1'b0, 1'b1, 1'b1);

        // Reset five cycles into CALC, then a clean impulse frame
        clr();
        fr_re[0] = 32'h0011_0000;
        fr_re[1] = 32'h1000_0000;
        send(1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("calc_busy", {s_ready, busy}, 2'b01);
        rst = 1'b1;
        #1;
        chk("midrst_now", {s_ready, m_valid, busy}, 3'b100);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_after", {s_ready, m_valid, busy}, 3'b100);
        clr();
        fr_re[0] = 32'h0001_0000;
        for (int i = 0; i < 8; i++) ex_re[i] = 32'h0001_0000;
        run(1'b0, 1'b0, 1'b0, 1'b0);

        chk("sb_empty", 96'(sb.size()), 96'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_iter_core.md
# fft_iter_core

Parametrised, sequential radix-2 decimation-in-time FFT engine, successor to the fixed 8-point combinational `eightpt` array. It accepts one frame of N complex fixed-point samples over a valid/ready stream and computes the transform in place, one butterfly per cycle. It then streams the N results out in natural order. Per-frame mode bits select forward/inverse transform and optional per-stage 1/2 scaling. It sits between the sample source and spectrum consumers in the FFT datapath.

## Interface
- `N`, 8: points per frame; power of 2, 4..1024
- `DATA_W`, 32: two's-complement width of each real/imag component
- `FRAC_W`, 16: fractional bits (default Q16.16, matching existing packed 32-bit buses)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  engine accepts input (LOAD state)
- `s_re`, `s_im`  in  DATA_W each  input sample real/imag
- `mode_inv`  in  1  1 = inverse transform (conjugated twiddles); sampled with sample 0
- `mode_scale`  in  1  1 = arithmetic shift right by 1 after every stage; sampled with sample 0
- `m_valid`  out  1  output sample valid
- `m_ready`  in  1  downstream accepts output
- `m_re`, `m_im`  out  DATA_W each  output bin real/imag
- `m_last`  out  1  high with bin N-1
- `busy`  out  1  high in CALC and UNLOAD

## Operation
- Storage: two N×DATA_W register arrays (re, im); not reset.
- States: LOAD → CALC → UNLOAD → LOAD.
- LOAD: `s_ready`=1. Each handshake writes sample k (0..N-1) to address bitrev(k, L), where L=log2 N. k=0 latches `mode_inv` and `mode_scale`. The handshake with k=N-1 moves the block to CALC.
- CALC: stage s=0..L-1, butterfly b=0..N/2-1, one per cycle.
  - Addressing: half=1<<s; top=((b>>s)<<(s+1)) | (b & (half-1)); bot=top+half.
  - Twiddle index: tw=(b & (half-1))<<(L-1-s).
  - Twiddle: W=cos(2π·tw/N) − j·sin(2π·tw/N). When `mode_inv`=1, the imaginary part is negated.
- Butterfly: t = W·x[bot], where each complex product term is full-width, summed, then arithmetic-shifted right by FRAC_W (truncation). x[top]'=x[top]+t; x[bot]'=x[top]−t.
  - Sums wrap modulo 2^DATA_W (no saturation).
  - If scale is set, each result is additionally shifted right by 1 (arithmetic).
  - Read and write-back both occur in the same cycle.
- After butterfly (L-1, N/2-1), the block moves to UNLOAD.
- UNLOAD: output index j=0..N-1.
  - `m_re`/`m_im` = array[j], read combinationally.
  - j advances on each `m_valid & m_ready`. `m_last` = (j==N-1).
  - The handshake on j=N-1 returns the block to LOAD.
- Forward with scale: result = DFT/N. Inverse with scale: result = true IDFT.

## Timing
- Reset values: state LOAD, all counters 0, `s_ready`=1, `m_valid`=0, `m_last`=0, `busy`=0, latched modes 0. `m_re`/`m_im` are don't-care while `m_valid`=0.
- `rst` asserted mid-frame (any state): the partial frame is discarded. The block is in LOAD with `s_ready`=1 on the first edge after deassertion.
- CALC lasts exactly L·N/2 cycles. If the last input handshake occurs at edge T, `m_valid` rises after edge T+1+L·N/2 (N=8: T+13).
- With `m_ready` held at 1, UNLOAD takes N cycles. `s_ready` is 1 in the cycle after the final output handshake.
- Stall: while `m_valid`=1 and `m_ready`=0, `m_re`, `m_im`, and `m_last` are held stable.
- Input is never accepted outside LOAD (`s_ready`=0). `s_valid` gaps in LOAD simply pause loading.
- Mode inputs are ignored on samples other than k=0.

## Structure
- Shared package `fft_pkg`:
  - `clog2` and `bitrev` functions.
  - A twiddle-constant function computing round-to-nearest Q(FRAC_W) cos/sin at elaboration.
  - State encoding (LOAD, CALC, UNLOAD).
- Sub-module `fft_bfly`: purely combinational complex butterfly with the scale and inverse controls.
- Twiddle ROM (N/2 entries) stays local to the core.

## Test plan (N=8, DATA_W=32, FRAC_W=16)
- Impulse: x0=0x0001_0000, rest 0, fwd, no scale → all 8 bins re=0x0001_0000, im=0; `m_valid` 13 cycles after the last input handshake.
- DC: all x=0x0001_0000, fwd, no scale → X0=0x0008_0000, X1..X7=0. Same input with scale → X0=0x0001_0000, others 0.
- Two-point input: x0=0x0011_0000, x1=0x1000_0000, rest 0, fwd, no scale →
  - X0 re=0x1011_0000, im=0.
  - X2 re=0x0011_0000, im=0xF000_0000.
  - X4 re=0xF011_0000, im=0.
  - X6 re=0x0011_0000, im=0x1000_0000.
- Inverse: X0=0x0008_0000, rest 0, inv, scale → all 8 outputs re=0x0001_0000, im=0.
- Backpressure: random `s_valid` gaps and `m_ready` toggling 1,0,1,0… on the DC test → identical bins, no drop or duplicate, outputs stable during stalls, `m_last` only on bin 7.
- Reset mid-CALC: assert `rst` 5 cycles into CALC → `m_valid`=0 and `s_ready`=1 immediately. The next impulse frame produces correct results.
